instruction_fetch: RTL and testbench

//  Fetch stage directly downstream of programme_counter: consumes the address
//  `add` it produces every cycle and reads program memory at that address.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo2.sv | 72 +++++++
 rtl/instruction_fetch.sv | 129 ++++++++++++
 tb/tb_instruction_fetch.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: fetch FSM states and default field widths.
package fetch_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_INSTR_W = 8;
  localparam int DEF_OPC_W   = 4;
  localparam int DEF_DEPTH   = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry FIFO for fetched words; entry 0 is always the head.
// Pushes into a full FIFO without a simultaneous pop are ignored.
module fetch_fifo2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         srst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  logic [W-1:0] ent0_r;
  logic [W-1:0] ent1_r;
  logic [1:0]   cnt_r;
  logic         do_pop_s;

  assign do_pop_s = pop & (cnt_r != 2'd0);

  // entry storage and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_r <= '0;
      ent1_r <= '0;
      cnt_r  <= 2'd0;
    end else if (srst) begin
      ent0_r <= '0;
      ent1_r <= '0;
      cnt_r  <= 2'd0;
    end else begin
      case ({push, do_pop_s})
        2'b10: begin
          if (cnt_r == 2'd0) begin
            ent0_r <= din;
            cnt_r  <= 2'd1;
          end else if (cnt_r == 2'd1) begin
            ent1_r <= din;
            cnt_r  <= 2'd2;
          end else begin
            cnt_r  <= cnt_r;
          end
        end
        2'b01: begin
          ent0_r <= ent1_r;
          ent1_r <= '0;
          cnt_r  <= cnt_r - 2'd1;
        end
        2'b11: begin
          // count unchanged; with one entry the new word becomes the head directly
          if (cnt_r == 2'd1) begin
            ent0_r <= din;
          end else begin
            ent0_r <= ent1_r;
            ent1_r <= din;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign full  = (cnt_r == 2'd2);
  assign empty = (cnt_r == 2'd0);
  assign head  = ent0_r;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: program memory, one-cycle read stage, load/run FSM and a
// 2-entry output buffer presenting {opcode, operand, address} over valid/ready.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int OPC_W   = DEF_OPC_W,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     power,
  input  logic [ADDR_W-1:0]        add,
  input  logic [ADDR_W-1:0]        last_add,
  input  logic                     load_en,
  input  logic [ADDR_W-1:0]        load_addr,
  input  logic [INSTR_W-1:0]       load_data,
  input  logic                     instr_ready,
  output logic                     instr_valid,
  output logic [INSTR_W-1:0]       instr,
  output logic [OPC_W-1:0]         opcode,
  output logic [INSTR_W-OPC_W-1:0] operand,
  output logic [ADDR_W-1:0]        instr_addr,
  output logic                     prog_end,
  output logic                     overrun
);

  localparam int OPR_W   = INSTR_W - OPC_W;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  fetch_state_e       state_r;
  fetch_state_e       state_nxt_s;
  logic               flush_s;
  logic [INSTR_W-1:0] mem_r [0:DEPTH-1];
  logic               rd_v_r;
  logic [INSTR_W-1:0] rd_data_r;
  logic [ADDR_W-1:0]  rd_addr_r;
  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               empty_s;
  logic [ENTRY_W-1:0] head_s;
  logic               prog_end_r;
  logic               overrun_r;

  // next-state logic; leaving RUN for LOAD discards everything in flight
  always_comb begin
    state_nxt_s = state_r;
    flush_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_en) state_nxt_s = LOAD;
        else         state_nxt_s = RUN;
      end
      LOAD: begin
        if (load_en) state_nxt_s = LOAD;
        else         state_nxt_s = RUN;
      end
      RUN: begin
        if (load_en) begin
          state_nxt_s = LOAD;
          flush_s     = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge power) begin
    if (!power) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // program memory keeps its contents across reset
  always_ff @(posedge clk) begin
    if ((state_r == LOAD) && load_en) mem_r[load_addr] <= load_data;
  end

  // read stage: one fetch per RUN cycle
  always_ff @(posedge clk or negedge power) begin
    if (!power) begin
      rd_v_r    <= 1'b0;
      rd_data_r <= '0;
      rd_addr_r <= '0;
    end else begin
      rd_v_r    <= (state_r == RUN) && !load_en;
      rd_data_r <= mem_r[add];
      rd_addr_r <= add;
    end
  end

  assign push_s = rd_v_r & ~flush_s;
  assign pop_s  = ~empty_s & instr_ready;

  fetch_fifo2 #(.W(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst_n (power),
    .srst  (flush_s),
    .push  (push_s),
    .pop   (pop_s),
    .din   ({rd_addr_r, rd_data_r}),
    .full  (full_s),
    .empty (empty_s),
    .head  (head_s)
  );

  // end-of-program pulse and sticky drop flag
  always_ff @(posedge clk or negedge power) begin
    if (!power) begin
      prog_end_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      prog_end_r <= pop_s && (head_s[ENTRY_W-1 -: ADDR_W] == last_add);
      overrun_r  <= overrun_r | (push_s & full_s & ~pop_s);
    end
  end

  assign instr_valid = ~empty_s;
  assign instr       = head_s[INSTR_W-1:0];
  assign opcode      = head_s[INSTR_W-1 -: OPC_W];
  assign operand     = head_s[OPR_W-1:0];
  assign instr_addr  = head_s[ENTRY_W-1 -: ADDR_W];
  assign prog_end    = prog_end_r;
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized traffic,
// all checked against a queue-based behavioural model.
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       power;
  logic [7:0] add, last_add, load_addr, load_data;
  logic       load_en, instr_ready;
  logic       instr_valid, prog_end, overrun;
  logic [7:0] instr, instr_addr;
  logic [3:0] opcode, operand;

  int checks = 0;
  int failures = 0;

  instruction_fetch dut (
    .clk(clk), .power(power), .add(add), .last_add(last_add),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .instr_ready(instr_ready), .instr_valid(instr_valid), .instr(instr),
    .opcode(opcode), .operand(operand), .instr_addr(instr_addr),
    .prog_end(prog_end), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // behavioural model: mode 0=idle 1=load 2=run, a pending read, and a 2-deep queue
  logic [7:0]  m_mem [256];
  int          m_mode;
  bit          m_rd_v;
  logic [15:0] m_rd;
  logic [15:0] m_buf [$];
  bit          m_ovr, m_pe;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_rd_v = 1'b0;
    m_buf.delete();
    m_ovr = 1'b0;
    m_pe = 1'b0;
  endtask

  task automatic model_step();
    bit pop;
    pop = (m_buf.size() != 0) && instr_ready;
    m_pe = 1'b0;
    if (pop) m_pe = (m_buf[0][15:8] == last_add);
    if (m_mode == 2 && load_en) begin
      m_buf.delete();
      m_rd_v = 1'b0;
      m_mode = 1;
    end else begin
      if (m_mode == 1 && load_en) m_mem[load_addr] = load_data;
      if (pop) void'(m_buf.pop_front());
      if (m_rd_v) begin
        if (m_buf.size() < 2) m_buf.push_back(m_rd);
        else m_ovr = 1'b1;
      end
      m_rd_v = (m_mode == 2);
      m_rd = {add, m_mem[add]};
      m_mode = load_en ? 1 : 2;
    end
  endtask

  task automatic check_model();
    logic [15:0] e;
    check_eq("valid", instr_valid, m_buf.size() != 0);
    if (m_buf.size() != 0) begin
      e = m_buf[0];
      check_eq("instr", instr, e[7:0]);
      check_eq("opcode", opcode, e[7:4]);
      check_eq("operand", operand, e[3:0]);
      check_eq("instr_addr", instr_addr, e[15:8]);
    end
    check_eq("prog_end", prog_end, m_pe);
    check_eq("overrun", overrun, m_ovr);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_valid"}, instr_valid, 1'b0);
    check_eq({tag, "_instr"}, instr, 8'h00);
    check_eq({tag, "_opcode"}, opcode, 4'h0);
    check_eq({tag, "_operand"}, operand, 4'h0);
    check_eq({tag, "_addr"}, instr_addr, 8'h00);
    check_eq({tag, "_prog_end"}, prog_end, 1'b0);
    check_eq({tag, "_overrun"}, overrun, 1'b0);
  endtask

  task automatic check_head(input string tag, input logic [7:0] w, input logic [7:0] a);
    check_eq({tag, "_valid"}, instr_valid, 1'b1);
    check_eq({tag, "_instr"}, instr, w);
    check_eq({tag, "_addr"}, instr_addr, a);
  endtask

  // one clock: check model vs DUT, drive inputs, advance model, wait for the next negedge
  task automatic cyc(input bit le, input logic [7:0] la, input logic [7:0] ld,
                     input logic [7:0] a, input bit rdy);
    check_model();
    load_en = le; load_addr = la; load_data = ld; add = a; instr_ready = rdy;
    model_step();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] pc;
    power = 1'b0; load_en = 1'b1; load_addr = 8'h00; load_data = 8'hFF;
    add = 8'h05; instr_ready = 1'b0; last_add = 8'h03;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("t1_reset");
    power = 1'b1;

    // load A1,B2,C3,D4 then stream addresses 0,1,2,3,0,1 with ready=1
    cyc(1'b1, 8'h00, 8'hA1, 8'h00, 1'b0);
    cyc(1'b1, 8'h00, 8'hA1, 8'h00, 1'b0);
    cyc(1'b1, 8'h01, 8'hB2, 8'h00, 1'b0);
    cyc(1'b1, 8'h02, 8'hC3, 8'h00, 1'b0);
    cyc(1'b1, 8'h03, 8'hD4, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 8'h00, 8'h01, 1'b1);
    check_head("t2_a1", 8'hA1, 8'h00);
    check_eq("t2_opcode", opcode, 4'hA);
    check_eq("t2_operand", operand, 4'h1);
    cyc(1'b0, 8'h00, 8'h00, 8'h02, 1'b1);
    check_head("t2_b2", 8'hB2, 8'h01);
    cyc(1'b0, 8'h00, 8'h00, 8'h03, 1'b1);
    check_head("t2_c3", 8'hC3, 8'h02);
    cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    check_head("t2_d4", 8'hD4, 8'h03);
    check_eq("t4_no_end_yet", prog_end, 1'b0);
    cyc(1'b0, 8'h00, 8'h00, 8'h01, 1'b1);
    check_eq("t4_prog_end", prog_end, 1'b1);
    check_head("t4_wrap_a1", 8'hA1, 8'h00);
    cyc(1'b0, 8'h00, 8'h00, 8'h02, 1'b1);
    check_eq("t4_prog_end_off", prog_end, 1'b0);

    // flush through LOAD, then back-pressure for 4 cycles
    cyc(1'b1, 8'h00, 8'hA1, 8'h00, 1'b0);
    check_eq("t3_flushed", instr_valid, 1'b0);
    cyc(1'b1, 8'h00, 8'hA1, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 8'h00, 8'(i), 1'b0);
    check_head("t3_hold_a1", 8'hA1, 8'h00);
    check_eq("t3_overrun", overrun, 1'b1);
    cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    check_head("t3_then_b2", 8'hB2, 8'h01);
    check_eq("t3_overrun_sticky", overrun, 1'b1);

    // asynchronous reset mid-run; memory must survive and ignore load_en
    #1;
    power = 1'b0; load_en = 1'b1; load_addr = 8'h00; load_data = 8'hFF;
    #1;
    check_zero("t5_async");
    model_reset();
    repeat (2) @(negedge clk);
    power = 1'b1;
    cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 8'h00, 8'h01, 1'b1);
    check_head("t5_mem_kept", 8'hA1, 8'h00);

    // reload mem[2] from RUN
    cyc(1'b1, 8'h02, 8'h7E, 8'h00, 1'b0);
    check_eq("t6_flush", instr_valid, 1'b0);
    cyc(1'b1, 8'h02, 8'h7E, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 8'h00, 8'h02, 1'b1);
    cyc(1'b0, 8'h00, 8'h00, 8'h03, 1'b1);
    check_head("t6_7e", 8'h7E, 8'h02);
    check_eq("t6_opcode", opcode, 4'h7);
    check_eq("t6_operand", operand, 4'hE);

    // randomized: fill whole memory, then PC-like traffic with random ready/load/reset
    cyc(1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 256; i++) cyc(1'b1, 8'(i), 8'($urandom), 8'h00, 1'b0);
    last_add = 8'($urandom_range(8, 255));
    pc = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #1 power = 1'b0;
        model_reset();
        @(negedge clk);
        power = 1'b1;
      end
      cyc($urandom_range(0, 39) == 0, 8'($urandom), 8'($urandom),
          ($urandom_range(0, 49) == 0) ? 8'($urandom) : pc,
          $urandom_range(0, 2) != 0);
      pc = (pc == last_add) ? 8'h00 : pc + 8'h01;
    end
    check_model();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
